neuron_fetch_scheduler: RTL and testbench

Layer-level sequencer for the neuron fetch path. It gates `neuron_fetch_en` strip by strip:
- waits until the neuron cache holds a loaded strip;
- runs the fetch while the downstream accumulator can accept data;
- detects end of strip from the fetch controller's delayed channel-switch pulse, then flushes the fetch pipeline.

After the configured number of strips it reports layer completion to the cnn_accelerator top-level control.

---
 rtl/neuron_fetch_scheduler.sv | 99 +++++++++
 tb/tb_neuron_fetch_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_fetch_scheduler.sv
// Strip-by-strip layer sequencer gating neuron_fetch_en: wait for cache, fetch, drain, repeat; then layer done.
// Latency: start -> WAIT_CACHE next cycle; fetch enable is zero-cycle from ready; downstream backpressure only masks fetch enable.
module neuron_fetch_scheduler #(
    parameter int PICTURE_HEIGHT_BIT_WIDTH = 5,
    parameter int FILTER_WIDTH_BIT_WIDTH   = 3,
    parameter int STRIP_CNT_BIT_WIDTH      = 6
) (
    input  logic                                clk,
    input  logic                                layer_reset,
    input  logic                                layer_start_i,
    input  logic [FILTER_WIDTH_BIT_WIDTH-1:0]   filter_width_i,
    input  logic [STRIP_CNT_BIT_WIDTH-1:0]      num_strips_i,
    input  logic                                cache_valid_i,
    input  logic                                downstream_ready_i,
    input  logic                                next_stage_en_i,
    input  logic                                channel_switch_en_i,
    output logic                                neuron_fetch_en_o,
    output logic                                strip_done_o,
    output logic                                layer_busy_o,
    output logic                                layer_done_o,
    output logic [PICTURE_HEIGHT_BIT_WIDTH-1:0] stage_cnt_o,
    output logic [STRIP_CNT_BIT_WIDTH-1:0]      strip_cnt_o
);

    localparam int DRAIN_W = FILTER_WIDTH_BIT_WIDTH + 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CACHE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    state_t                              state;
    state_t                              state_nxt;
    logic [DRAIN_W-1:0]                  drain_cnt;
    logic [PICTURE_HEIGHT_BIT_WIDTH-1:0] stage_cnt;
    logic [STRIP_CNT_BIT_WIDTH-1:0]      strip_cnt;
    logic                                strip_done_q;
    logic                                drain_last;
    logic                                last_strip;

    assign drain_last = (drain_cnt == DRAIN_W'(1));
    assign last_strip = (strip_cnt == num_strips_i);

    always_comb begin
        state_nxt         = state;
        neuron_fetch_en_o = 1'b0;
        case (state)
            IDLE:       if (layer_start_i) state_nxt = WAIT_CACHE;
            WAIT_CACHE: if (cache_valid_i) state_nxt = FETCH;
            FETCH: begin
                neuron_fetch_en_o = downstream_ready_i;
                if (channel_switch_en_i) state_nxt = DRAIN;
            end
            DRAIN:      if (drain_last) state_nxt = last_strip ? DONE : WAIT_CACHE;
            DONE:       state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            state        <= IDLE;
            drain_cnt    <= '0;
            stage_cnt    <= '0;
            strip_cnt    <= '0;
            strip_done_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            strip_done_q <= (state == FETCH) && channel_switch_en_i;
            case (state)
                IDLE:       if (layer_start_i) strip_cnt <= '0;
                WAIT_CACHE: if (cache_valid_i) stage_cnt <= '0;
                FETCH: begin
                    // Stage count saturates so tall pictures never alias back to small values.
                    if (next_stage_en_i && (stage_cnt != '1))
                        stage_cnt <= stage_cnt + PICTURE_HEIGHT_BIT_WIDTH'(1);
                    if (channel_switch_en_i)
                        drain_cnt <= DRAIN_W'(filter_width_i) + DRAIN_W'(2);
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt - DRAIN_W'(1);
                    if (drain_last && !last_strip)
                        strip_cnt <= strip_cnt + STRIP_CNT_BIT_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

    assign strip_done_o = strip_done_q;
    assign layer_busy_o = (state != IDLE);
    assign layer_done_o = (state == DONE);
    assign stage_cnt_o  = stage_cnt;
    assign strip_cnt_o  = strip_cnt;

endmodule

// File: tb/tb_neuron_fetch_scheduler.sv
// Randomized bench for neuron_fetch_scheduler with a cycle-level behavioural model and per-layer literal checks.
module tb_neuron_fetch_scheduler;

    localparam int P_IDLE = 0, P_WAIT = 1, P_FETCH = 2, P_DRAIN = 3, P_DONE = 4;

    logic       clk = 1'b0;
    logic       layer_reset = 1'b1;
    logic       layer_start = 1'b0;
    logic [2:0] filter_width = 3'd0;
    logic [5:0] num_strips = 6'd0;
    logic       cache_valid = 1'b0;
    logic       downstream_ready = 1'b0;
    logic       next_stage = 1'b0;
    logic       channel_switch = 1'b0;
    logic       neuron_fetch_en_o;
    logic       strip_done_o;
    logic       layer_busy_o;
    logic       layer_done_o;
    logic [4:0] stage_cnt_o;
    logic [5:0] strip_cnt_o;

    neuron_fetch_scheduler dut (
        .clk                 (clk),
        .layer_reset         (layer_reset),
        .layer_start_i       (layer_start),
        .filter_width_i      (filter_width),
        .num_strips_i        (num_strips),
        .cache_valid_i       (cache_valid),
        .downstream_ready_i  (downstream_ready),
        .next_stage_en_i     (next_stage),
        .channel_switch_en_i (channel_switch),
        .neuron_fetch_en_o   (neuron_fetch_en_o),
        .strip_done_o        (strip_done_o),
        .layer_busy_o        (layer_busy_o),
        .layer_done_o        (layer_done_o),
        .stage_cnt_o         (stage_cnt_o),
        .strip_cnt_o         (strip_cnt_o)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Behavioural model: phase, unbounded stage count, strip index, drain cycles left.
    int m_ph = P_IDLE;
    int m_stages = 0;
    int m_strip = 0;
    int m_drain = 0;
    int m_sd = 0;

    always @(posedge clk or posedge layer_reset) begin
        if (layer_reset) begin
            m_ph <= P_IDLE; m_stages <= 0; m_strip <= 0; m_drain <= 0; m_sd <= 0;
        end else begin
            m_sd <= 0;
            case (m_ph)
                P_IDLE: if (layer_start) begin m_ph <= P_WAIT; m_strip <= 0; end
                P_WAIT: if (cache_valid) begin m_ph <= P_FETCH; m_stages <= 0; end
                P_FETCH: begin
                    if (next_stage) m_stages <= m_stages + 1;
                    if (channel_switch) begin
                        m_ph <= P_DRAIN; m_drain <= int'(filter_width) + 2; m_sd <= 1;
                    end
                end
                P_DRAIN: begin
                    m_drain <= m_drain - 1;
                    if (m_drain == 1) begin
                        if (m_strip == int'(num_strips)) m_ph <= P_DONE;
                        else begin m_strip <= m_strip + 1; m_ph <= P_WAIT; end
                    end
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    // Per-cycle comparison and event statistics, sampled mid-cycle.
    int s_idx = 0;
    int n_sd = 0, n_ld = 0, st_start = -1, st_sd = -1, st_done = -1;
    int sd_strips[$];

    always @(negedge clk) begin
        s_idx <= s_idx + 1;
        chk("fetch_en", int'(neuron_fetch_en_o), int'(m_ph == P_FETCH && downstream_ready));
        chk("strip_done", int'(strip_done_o), m_sd);
        chk("busy", int'(layer_busy_o), int'(m_ph != P_IDLE));
        chk("layer_done", int'(layer_done_o), int'(m_ph == P_DONE));
        chk("stage_cnt", int'(stage_cnt_o), (m_stages > 31) ? 31 : m_stages);
        chk("strip_cnt", int'(strip_cnt_o), m_strip);
        if (layer_start && m_ph == P_IDLE && !layer_reset) st_start <= s_idx;
        if (strip_done_o) begin n_sd <= n_sd + 1; sd_strips.push_back(int'(strip_cnt_o)); st_sd <= s_idx; end
        if (layer_done_o) begin n_ld <= n_ld + 1; st_done <= s_idx; end
    end

    int rdy_mode = 0;  // 0: ready held high, 1: toggle each cycle, 2: random

    task automatic step();
        @(posedge clk);
        #1;
        layer_start = 1'b0; next_stage = 1'b0; channel_switch = 1'b0;
    endtask

    task automatic clear_stats();
        n_sd = 0; n_ld = 0; st_start = -1; st_sd = -1; st_done = -1;
        sd_strips.delete();
    endtask

    task automatic wait_phase(input int target, input int budget);
        int k = 0;
        while (m_ph != target && k < budget) begin
            if (rdy_mode != 0) downstream_ready = 1'($urandom_range(0, 1));
            step();
            k++;
        end
        if (m_ph != target) begin
            n_total++;
            $display("FAIL wait_phase: phase %0d, expected %0d within %0d cycles", m_ph, target, budget);
        end
    endtask

    // nse_mode: 0 random next_stage, 1 every fetch cycle, 2 every cycle incl. the channel-switch cycle.
    task automatic run_layer(input int fw, input int ns, input int cwait, input int nfetch, input int nse_mode);
        filter_width = 3'(fw);
        num_strips = 6'(ns);
        cache_valid = (cwait == 0);
        if (rdy_mode == 0) downstream_ready = 1'b1;
        layer_start = 1'b1;
        step();
        for (int s = 0; s <= ns; s++) begin
            for (int w = 0; w < cwait; w++) begin
                channel_switch = (w == 0 && nse_mode == 2) || ($urandom_range(0, 3) == 0);
                next_stage = 1'($urandom_range(0, 1));
                if (rdy_mode != 0) downstream_ready = 1'($urandom_range(0, 1));
                step();
            end
            cache_valid = 1'b1;
            step();
            if (cwait > 0) cache_valid = 1'b0;
            for (int f = 0; f < nfetch; f++) begin
                next_stage = (nse_mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (rdy_mode == 1) downstream_ready = ~downstream_ready;
                else if (rdy_mode == 2) downstream_ready = 1'($urandom_range(0, 1));
                if (f == 1) layer_start = 1'b1;
                step();
            end
            channel_switch = 1'b1;
            next_stage = (nse_mode == 2) ? 1'b1 : (nse_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            step();
            wait_phase((s == ns) ? P_IDLE : P_WAIT, 20);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", int'(layer_busy_o), 0);
        chk("reset_fetch_en", int'(neuron_fetch_en_o), 0);
        chk("reset_stage", int'(stage_cnt_o), 0);
        chk("reset_strip", int'(strip_cnt_o), 0);
        layer_reset = 1'b0;
        step();

        // Single strip: F = 5 fetch cycles, filter width 2 -> drain 4, inclusive length 2+5+4+1.
        clear_stats(); rdy_mode = 0;
        run_layer(2, 0, 0, 4, 1);
        chk("single_stage", int'(stage_cnt_o), 4);
        chk("single_sd_cnt", n_sd, 1);
        chk("single_ld_cnt", n_ld, 1);
        chk("single_drain_len", st_done - st_sd, 4);
        chk("single_layer_len", st_done - st_start + 1, 12);
        chk("single_busy_end", int'(layer_busy_o), 0);

        // Multi-strip with cache waits.
        clear_stats(); rdy_mode = 2;
        run_layer(1, 2, 5, 6, 0);
        chk("multi_sd_cnt", n_sd, 3);
        chk("multi_ld_cnt", n_ld, 1);
        chk("multi_sd_q_size", sd_strips.size(), 3);
        for (int i = 0; i < sd_strips.size() && i < 3; i++) chk($sformatf("multi_sd_strip%0d", i), sd_strips[i], i);

        // Backpressure toggling.
        clear_stats(); rdy_mode = 1;
        run_layer(3, 1, 3, 10, 0);
        chk("bp_sd_cnt", n_sd, 2);

        // Simultaneous next_stage + channel_switch, stray switch in WAIT_CACHE, start during FETCH.
        clear_stats(); rdy_mode = 0;
        run_layer(1, 0, 2, 2, 2);
        chk("simul_stage", int'(stage_cnt_o), 3);
        chk("simul_sd_cnt", n_sd, 1);

        // Drain boundaries and stage saturation.
        clear_stats();
        run_layer(0, 0, 0, 3, 1);
        chk("fw0_drain_len", st_done - st_sd, 2);
        chk("fw0_layer_len", st_done - st_start + 1, 9);
        clear_stats();
        run_layer(5, 0, 0, 40, 1);
        chk("fw5_drain_len", st_done - st_sd, 7);
        chk("fw5_stage_sat", int'(stage_cnt_o), 31);

        // Reset in the middle of strip 1 FETCH.
        rdy_mode = 0; downstream_ready = 1'b1; filter_width = 3'd1; num_strips = 6'd2; cache_valid = 1'b1;
        layer_start = 1'b1; step(); step();
        channel_switch = 1'b1; step();
        wait_phase(P_FETCH, 20);
        next_stage = 1'b1; step();
        chk("pre_reset_fetch_en", int'(neuron_fetch_en_o), 1);
        chk("pre_reset_strip", int'(strip_cnt_o), 1);
        #2 layer_reset = 1'b1;
        #1;
        chk("rst_fetch_en", int'(neuron_fetch_en_o), 0);
        chk("rst_busy", int'(layer_busy_o), 0);
        chk("rst_strip_done", int'(strip_done_o), 0);
        chk("rst_layer_done", int'(layer_done_o), 0);
        chk("rst_stage", int'(stage_cnt_o), 0);
        chk("rst_strip", int'(strip_cnt_o), 0);
        @(posedge clk);
        #2 layer_reset = 1'b0;
        step();
        clear_stats();
        run_layer(1, 2, 1, 3, 0);
        chk("post_rst_sd_cnt", n_sd, 3);
        chk("post_rst_first_strip", (sd_strips.size() > 0) ? sd_strips[0] : -1, 0);
        chk("post_rst_ld_cnt", n_ld, 1);

        // Randomized layers.
        for (int r = 0; r < 8; r++) begin
            int ns;
            ns = $urandom_range(0, 3);
            clear_stats();
            rdy_mode = $urandom_range(0, 2);
            run_layer($urandom_range(0, 5), ns, $urandom_range(0, 4), $urandom_range(1, 8), $urandom_range(0, 2));
            chk($sformatf("rand%0d_sd_cnt", r), n_sd, ns + 1);
            chk($sformatf("rand%0d_ld_cnt", r), n_ld, 1);
        end

        step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
